// File: rtl/rnm_multi_accum_pkg.sv
// Shared types and real-valued helpers for the multi-channel RNM accumulator.
package rnm_accum_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

   localparam real LIMIT_DEF = 1.0e6;

   // x - x is 0.0 for every finite x, NaN for NaN and +/-Inf
   function automatic logic is_nonfinite(real x);
      return !((x - x) == 0.0);
   endfunction

   function automatic real clamp(real x, real lim);
      if (x > lim) return lim;
      if (x < -lim) return -lim;
      return x;
   endfunction

endpackage

// File: rtl/rnm_multi_accum_if.sv
// Shared update port plus per-channel status/result bus of the accumulator.
interface rnm_multi_accum_if #(
   parameter int NCH   = 4,
   parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int DEPTH = 2,
   parameter int CNTW  = 16
);
   logic                      in_valid;
   logic [CHW-1:0]            in_ch;
   real                       incr;
   logic [NCH-1:0]            clr;
   real                       q    [NCH];
   real                       hist [NCH][DEPTH];
   logic [NCH-1:0][CNTW-1:0]  cnt;
   logic [NCH-1:0]            sat;
   logic [NCH-1:0]            fault;
   logic                      in_err;

   modport master (output in_valid, in_ch, incr, clr,
                   input  q, hist, cnt, sat, fault, in_err);
   modport slave  (input  in_valid, in_ch, incr, clr,
                   output q, hist, cnt, sat, fault, in_err);
endinterface

// File: rtl/rnm_multi_accum_chan.sv
// One accumulator channel: IDLE/RUN/FAULT FSM, clamped q, history, saturating count.
module rnm_accum_chan
   import rnm_accum_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter int  CNTW  = 16,
   parameter real LIMIT = LIMIT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            upd,
   input  real             incr,
   input  logic            clr,
   output real             q,
   output real             hist [DEPTH],
   output logic [CNTW-1:0] cnt,
   output logic            sat,
   output logic            fault
);

   state_t state;
   real    s;
   logic   take;

   always_comb begin
      s    = q + incr;
      take = upd && (state != FAULT) && !is_nonfinite(incr);
   end

   assign fault = (state == FAULT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state <= IDLE;
         q     <= 0.0;
         cnt   <= '0;
         sat   <= 1'b0;
         for (int k = 0; k < DEPTH; k++) hist[k] <= 0.0;
      end else if (upd && state != FAULT) begin
         if (is_nonfinite(incr)) begin
            state <= FAULT;
         end else begin
            state   <= RUN;
            q       <= clamp(s, LIMIT);
            sat     <= (s > LIMIT) || (s < -LIMIT);
            hist[0] <= q;
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
            if (cnt != {CNTW{1'b1}}) cnt <= cnt + 1'b1;
         end
      end
   end

   // Invariant checks look one cycle back, so they compare settled register values.
   real  q_prev;
   logic fault_chk;
   logic mono_chk;

   always_ff @(posedge clk) begin
      q_prev    <= q;
      fault_chk <= !rst && !clr && (state == FAULT);
      mono_chk  <= !rst && !clr && take && (state == RUN) && (incr > 0.0);
      assert (q >= -LIMIT && q <= LIMIT);
      if (fault_chk) assert (q == q_prev);
      if (mono_chk) assert (hist[0] <= q);
   end

endmodule

// File: rtl/rnm_multi_accum.sv
// NCH-channel real accumulator behind one shared update port; decodes in_ch and flags rejects.
module rnm_multi_accum
   import rnm_accum_pkg::*;
#(
   parameter int  NCH   = 4,
   parameter int  CHW   = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int  DEPTH = 2,
   parameter real LIMIT = LIMIT_DEF,
   parameter int  CNTW  = 16
) (
   input logic               clk,
   input logic               rst,
   rnm_multi_accum_if.slave  bus
);

   logic in_range;
   logic sel_fault;
   logic sel_clr;
   logic rej;

   always_comb begin
      in_range  = int'(bus.in_ch) < NCH;
      sel_fault = 1'b0;
      sel_clr   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.in_ch == CHW'(i)) begin
            sel_fault = bus.fault[i];
            sel_clr   = bus.clr[i];
         end
      end
      // A clear on the target channel swallows the update without an error
      rej = bus.in_valid && !(in_range && sel_clr) &&
            (!in_range || sel_fault || is_nonfinite(bus.incr));
   end

   always_ff @(posedge clk) begin
      if (rst) bus.in_err <= 1'b0;
      else     bus.in_err <= rej;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic upd;
      assign upd = bus.in_valid && in_range && (bus.in_ch == CHW'(i));

      rnm_accum_chan #(
         .DEPTH (DEPTH),
         .CNTW  (CNTW),
         .LIMIT (LIMIT)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .upd   (upd),
         .incr  (bus.incr),
         .clr   (bus.clr[i]),
         .q     (bus.q[i]),
         .hist  (bus.hist[i]),
         .cnt   (bus.cnt[i]),
         .sat   (bus.sat[i]),
         .fault (bus.fault[i])
      );
   end

endmodule

// File: doc/rnm_multi_accum.md
Name: rnm_multi_accum

Overview:
- Multi-channel real-valued (RNM) accumulator for formal and simulation benches.
- Generalises the single-channel flop accumulator with the following:
  - NCH independent channels with one shared input port, selected by channel index.
  - Symmetric saturation limit.
  - Non-finite (NaN/Inf) input detection, with a sticky per-channel fault state.
  - Per-channel DEPTH-deep history of accepted values and a saturating sample counter.
- Sits between analog-model stimulus and property checkers. Checkers consume hist and the status flags.

Parameters:
- NCH, 4, number of channels (1..16).
- CHW, $clog2(NCH) (minimum 1), width of the channel index.
- DEPTH, 2, history entries kept per channel (1..8).
- LIMIT, 1.0e6, saturation magnitude. q is clamped to [-LIMIT, +LIMIT].
- CNTW, 16, sample counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an update request is present this cycle.
- in_ch  input  CHW  target channel of the update.
- incr  input  real  increment to add.
- clr  input  NCH  per-channel synchronous clear.
- q  output  real[NCH]  accumulator value per channel.
- hist  output  real[NCH][DEPTH]  past q values; index 0 is the most recent.
- cnt  output  CNTW[NCH]  accepted-sample count, saturating.
- sat  output  NCH  last accepted update was clamped.
- fault  output  NCH  channel is in FAULT state.
- in_err  output  1  registered: the previous cycle's in_valid was rejected (fault channel, non-finite incr, or in_ch >= NCH).

Behaviour:
- Reset (rst=1 at posedge), applied to all channels:
  - q=0.0, hist=0.0, cnt=0, sat=0, fault=0, in_err=0.
  - State = IDLE.
  - rst overrides clr and in_valid.
- Non-finite test: nf(x) = !((x - x) == 0.0). This is true for NaN, +Inf and -Inf; false for all finite values, including huge ones.
- Per-channel FSM, states IDLE, RUN, FAULT:
  - IDLE -> RUN on the first accepted update.
  - IDLE or RUN -> FAULT when in_valid targets the channel with nf(incr).
  - FAULT is left only by clr[ch] or rst.
- Accepted update: in_valid, in_ch < NCH, channel not in FAULT, !nf(incr). Then, at the next posedge:
  - s = q[ch] + incr.
  - q[ch] = clamp(s, -LIMIT, +LIMIT).
  - sat[ch] = (s > LIMIT || s < -LIMIT).
  - hist[ch] shifts: hist[ch][0] = old q[ch], hist[ch][k] = old hist[ch][k-1].
  - cnt[ch] increments, saturating at 2^CNTW-1.
  - Latency is 1 cycle. q is never updated combinationally.
- Rejected update:
  - No change to q, hist, cnt or sat of any channel.
  - in_err=1 for one cycle.
  - If the rejection cause is nf(incr) on a non-FAULT channel, that channel enters FAULT and fault[ch]=1.
  - An out-of-range in_ch affects no channel.
- in_err is 0 in every cycle following a cycle without a rejected in_valid.
- clr[ch]=1:
  - Channel returns to IDLE; q, hist, cnt, sat and fault are zeroed.
  - clr has priority over a simultaneous update on the same channel; that update is dropped silently, without in_err.
  - Other channels update normally in the same cycle.
- Only one channel updates per cycle; there is no multi-channel write.
- Invariants (asserted in the module):
  - -LIMIT <= q[ch] <= LIMIT.
  - fault[ch] implies q[ch] is stable while clr[ch]=0 and rst=0.
  - RUN and incr>0 and !sat imply hist[ch][0] <= q[ch] one cycle later.

Decomposition:
- Package rnm_accum_pkg contains:
  - typedef enum state_t {IDLE, RUN, FAULT}.
  - function is_nonfinite(real).
  - function clamp(real, real).
  - Default LIMIT constant.
- One natural sub-module, rnm_accum_chan: a single channel's FSM, q, hist, cnt and sat.
  - Inputs: upd, incr, clr.
  - Outputs: q, hist, cnt, sat, fault.
  - The top level generates NCH instances, decodes in_ch and computes in_err.

Test Plan:
- Reset, then ch0 gets incr 1.5, 2.0, 0.25 on consecutive cycles -> q[0] = 1.5, 3.5, 3.75; hist[0][0]=3.5, hist[0][1]=1.5; cnt[0]=3; other channels remain 0.
- LIMIT=10.0; ch1 gets 8.0 then 5.0 -> q[1]=10.0, sat[1]=1; then -3.0 -> q[1]=7.0, sat[1]=0.
- ch2 gets incr=NaN (0.0/0.0), then 1.0 -> fault[2]=1, in_err pulses on both, q[2] stays 0.0; then clr[2] and 1.0 -> q[2]=1.0, fault=0.
- incr=+Inf on ch3 -> FAULT. incr=1.0e300 on ch0 with LIMIT=1.0e301 -> accepted, no fault (not flagged as Inf).
- Same cycle: clr[1]=1, in_valid in_ch=1 incr=4.0 -> q[1]=0.0, in_err=0. in_ch=NCH -> in_err=1, all channels unchanged.
- Update on ch0 while rst=1 -> all outputs zero next cycle. cnt saturation with CNTW=2: 5 updates -> cnt=3.
